// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard-unit controls, decode redirects,
// instruction-memory port and the IF/ID register outputs.
interface fetch_stage_if;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        pc_src_d;
   logic [31:0] pc_branch_d;
   logic        jump_d;
   logic [25:0] jump_target_d;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instr_d;
   logic [31:0] pc_plus1_d;
   logic        valid_d;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   // Fetch stage side
   modport master (
      input  stall_f, stall_d, flush_d, pc_src_d, pc_branch_d, jump_d,
             jump_target_d, imem_data,
      output imem_addr, instr_d, pc_plus1_d, valid_d, fetch_count, stall_count
   );

   // Surrounding pipeline / memory side
   modport slave (
      output stall_f, stall_d, flush_d, pc_src_d, pc_branch_d, jump_d,
             jump_target_d, imem_data,
      input  imem_addr, instr_d, pc_plus1_d, valid_d, fetch_count, stall_count
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: word-indexed PC, IF/ID register and
// fetch/stall performance counters. All addresses are word indices.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int unsigned IMEM_DEPTH = 256
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_stage_if.master bus
);

   // IMEM_DEPTH is a power of two, so wrapping is a simple mask
   localparam logic [31:0] ADDR_MASK = 32'(IMEM_DEPTH - 32'd1);

   logic [31:0] pc_q,          pc_d;
   logic [31:0] ifid_instr_q,  ifid_instr_d;
   logic [31:0] ifid_pp1_q,    ifid_pp1_d;
   logic        ifid_valid_q,  ifid_valid_d;
   logic [31:0] fetch_cnt_q,   fetch_cnt_d;
   logic [31:0] stall_cnt_q,   stall_cnt_d;

   logic [31:0] pc_plus1_s;
   logic        redirect_s;
   logic        flush_s;

   // Next-PC selection: jump beats branch, any redirect beats stall_f
   always_comb begin
      pc_plus1_s = (pc_q + 32'd1) & ADDR_MASK;
      redirect_s = bus.jump_d | bus.pc_src_d;
      pc_d       = pc_q;
      if (bus.jump_d) begin
         pc_d = {ifid_pp1_q[31:26], bus.jump_target_d} & ADDR_MASK;
      end else if (bus.pc_src_d) begin
         pc_d = bus.pc_branch_d & ADDR_MASK;
      end else if (bus.stall_f) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus1_s;
      end
   end

   // IF/ID next state: a redirect squashes the wrong-path fetch like flush_d
   always_comb begin
      flush_s      = bus.flush_d | redirect_s;
      ifid_instr_d = ifid_instr_q;
      ifid_pp1_d   = ifid_pp1_q;
      ifid_valid_d = ifid_valid_q;
      fetch_cnt_d  = fetch_cnt_q;
      if (flush_s) begin
         ifid_instr_d = 32'd0;
         ifid_pp1_d   = 32'd0;
         ifid_valid_d = 1'b0;
      end else if (bus.stall_d) begin
         ifid_instr_d = ifid_instr_q;
         ifid_pp1_d   = ifid_pp1_q;
         ifid_valid_d = ifid_valid_q;
      end else begin
         ifid_instr_d = bus.imem_data;
         ifid_pp1_d   = pc_plus1_s;
         ifid_valid_d = 1'b1;
         fetch_cnt_d  = fetch_cnt_q + 32'd1;
      end
   end

   // Stall counter: a redirected cycle is not a stalled cycle
   always_comb begin
      if (bus.stall_f && !redirect_s) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= 32'd0;
         ifid_pp1_q   <= 32'd0;
         ifid_valid_q <= 1'b0;
         fetch_cnt_q  <= 32'd0;
         stall_cnt_q  <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pp1_q   <= ifid_pp1_d;
         ifid_valid_q <= ifid_valid_d;
         fetch_cnt_q  <= fetch_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.instr_d     = ifid_instr_q;
   assign bus.pc_plus1_d  = ifid_pp1_q;
   assign bus.valid_d     = ifid_valid_q;
   assign bus.fetch_count = fetch_cnt_q;
   assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: spec-level model compared every
// falling edge, plus hand-computed directed checks.
module tb_fetch_stage;
   localparam int unsigned DEPTH = 256;

   logic clk;
   logic reset_n;
   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'd0), .IMEM_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [31:0] imem_mem [DEPTH];
   assign bus.imem_data = imem_mem[bus.imem_addr[7:0]];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_instr, m_pp1, m_fc, m_sc;
   logic        m_valid;

   always @(posedge clk or negedge reset_n) begin
      logic [31:0] seq, tgt, npc;
      logic        redir;
      if (!reset_n) begin
         m_pc = 32'd0; m_instr = 32'd0; m_pp1 = 32'd0;
         m_valid = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
      end else begin
         seq   = (m_pc + 32'd1) % DEPTH;
         redir = bus.jump_d || bus.pc_src_d;
         tgt   = {m_pp1[31:26], bus.jump_target_d};
         if (bus.jump_d)        npc = tgt % DEPTH;
         else if (bus.pc_src_d) npc = bus.pc_branch_d % DEPTH;
         else if (bus.stall_f)  npc = m_pc;
         else                   npc = seq;
         if (bus.stall_f && !redir) m_sc = m_sc + 32'd1;
         if (redir || bus.flush_d) begin
            m_instr = 32'd0; m_pp1 = 32'd0; m_valid = 1'b0;
         end else if (!bus.stall_d) begin
            m_instr = imem_mem[m_pc]; m_pp1 = seq; m_valid = 1'b1;
            m_fc = m_fc + 32'd1;
         end
         m_pc = npc;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      chk("imem_addr",   bus.imem_addr,   m_pc);
      chk("instr_d",     bus.instr_d,     m_instr);
      chk("pc_plus1_d",  bus.pc_plus1_d,  m_pp1);
      chk("valid_d",     {31'd0, bus.valid_d}, {31'd0, m_valid});
      chk("fetch_count", bus.fetch_count, m_fc);
      chk("stall_count", bus.stall_count, m_sc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      bus.stall_f = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
      bus.pc_src_d = 1'b0; bus.pc_branch_d = 32'd0;
      bus.jump_d = 1'b0; bus.jump_target_d = 26'd0;
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      for (int i = 0; i < int'(DEPTH); i++) imem_mem[i] = 32'h1000_0000 + 32'(i);
      clear_ctl();
      reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_addr",  bus.imem_addr, 32'd0);
      chk("rst_valid", {31'd0, bus.valid_d}, 32'd0);
      reset_n = 1'b1;

      // Sequential fetch from reset
      tick(); chk("seq_addr1", bus.imem_addr, 32'd1);
      chk("seq_instr1", bus.instr_d, 32'h1000_0000);
      chk("seq_valid1", {31'd0, bus.valid_d}, 32'd1);
      tick(); chk("seq_addr2", bus.imem_addr, 32'd2);
      tick(); chk("seq_addr3", bus.imem_addr, 32'd3);
      chk("seq_fc3", bus.fetch_count, 32'd3);
      chk("seq_instr3", bus.instr_d, 32'h1000_0002);
      repeat (2) tick();              // pc = 5

      // Stall two cycles at pc=5
      bus.stall_f = 1'b1; bus.stall_d = 1'b1;
      repeat (2) tick();
      chk("stall_addr", bus.imem_addr, 32'd5);
      chk("stall_instr", bus.instr_d, 32'h1000_0004);
      chk("stall_cnt", bus.stall_count, 32'd2);
      clear_ctl();
      tick(); chk("rel_addr", bus.imem_addr, 32'd6);
      chk("rel_instr", bus.instr_d, 32'h1000_0005);
      tick(); chk("rel_next", bus.instr_d, 32'h1000_0006);
      chk("rel_fc", bus.fetch_count, 32'd7);

      // Jump to 40
      bus.jump_d = 1'b1; bus.jump_target_d = 26'd40;
      tick(); chk("jmp_addr", bus.imem_addr, 32'd40);
      chk("jmp_valid", {31'd0, bus.valid_d}, 32'd0);
      chk("jmp_instr", bus.instr_d, 32'd0);
      chk("jmp_fc", bus.fetch_count, 32'd7);
      clear_ctl();
      tick(); chk("jmp_instr2", bus.instr_d, 32'h1000_0028);
      chk("jmp_pp1", bus.pc_plus1_d, 32'd41);

      // Branch overrides stall; stall_count unchanged
      bus.stall_f = 1'b1; bus.stall_d = 1'b1;
      bus.pc_src_d = 1'b1; bus.pc_branch_d = 32'h20;
      tick(); chk("br_addr", bus.imem_addr, 32'h20);
      chk("br_scnt", bus.stall_count, 32'd2);
      clear_ctl();
      // Jump beats branch
      bus.jump_d = 1'b1; bus.jump_target_d = 26'd1;
      bus.pc_src_d = 1'b1; bus.pc_branch_d = 32'h50;
      tick(); chk("jb_addr", bus.imem_addr, 32'd1);
      clear_ctl();

      // Wrap at top of memory
      bus.pc_src_d = 1'b1; bus.pc_branch_d = 32'd254;
      tick(); clear_ctl();
      tick(); chk("wrap_255", bus.imem_addr, 32'd255);
      tick(); chk("wrap_0", bus.imem_addr, 32'd0);
      chk("wrap_pp1", bus.pc_plus1_d, 32'd0);
      chk("wrap_instr", bus.instr_d, 32'h1000_00FF);
      bus.pc_src_d = 1'b1; bus.pc_branch_d = 32'h0001_0003;
      tick(); chk("br_mask", bus.imem_addr, 32'd3);
      clear_ctl();

      // stall_f without stall_d: IF/ID reloads, pc holds
      tick();                         // pc=4
      bus.stall_f = 1'b1;
      tick(); chk("sf_addr", bus.imem_addr, 32'd4);
      chk("sf_instr", bus.instr_d, 32'h1000_0004);
      tick(); chk("sf_instr2", bus.instr_d, 32'h1000_0004);
      clear_ctl();

      // Flush beats stall_d
      tick();
      bus.flush_d = 1'b1; bus.stall_d = 1'b1; bus.stall_f = 1'b1;
      tick(); chk("fl_instr", bus.instr_d, 32'd0);
      chk("fl_valid", {31'd0, bus.valid_d}, 32'd0);
      clear_ctl();
      tick(); tick();

      // Asynchronous reset mid-cycle
      #2 reset_n = 1'b0;
      #1;
      chk("ar_addr", bus.imem_addr, 32'd0);
      chk("ar_instr", bus.instr_d, 32'd0);
      chk("ar_valid", {31'd0, bus.valid_d}, 32'd0);
      chk("ar_fc", bus.fetch_count, 32'd0);
      chk("ar_sc", bus.stall_count, 32'd0);
      tick();
      reset_n = 1'b1;
      tick(); tick();
      chk("post_addr", bus.imem_addr, 32'd2);
      chk("post_fc", bus.fetch_count, 32'd2);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipelined processor.
- Owns the word-indexed program counter and drives the instruction memory's word address.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Applies stall, flush and branch/jump redirects from the hazard unit and decode stage, and keeps two fetch performance counters.

Parameters:
- RESET_PC, 0, word index loaded into PC on reset.
- IMEM_DEPTH, 256, instruction memory depth in words; power of two; PC arithmetic wraps modulo this value.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- stall_f  in  1  hold PC (hazard unit).
- stall_d  in  1  hold IF/ID register (hazard unit).
- flush_d  in  1  load bubble into IF/ID (hazard unit).
- pc_src_d  in  1  branch taken, resolved in decode.
- pc_branch_d  in  32  branch target, word index.
- jump_d  in  1  jump in decode.
- jump_target_d  in  26  jump instr[25:0], word index.
- imem_addr  out  32  word address to instruction memory (combinational = pc).
- imem_data  in  32  instruction word from memory, combinational read.
- instr_d  out  32  IF/ID instruction.
- pc_plus1_d  out  32  IF/ID word index of the next sequential instruction.
- valid_d  out  1  IF/ID holds a real fetched instruction.
- fetch_count  out  32  count of valid instructions loaded into IF/ID.
- stall_count  out  32  count of cycles with stall_f held and no redirect.

Behaviour:
- All addressing is in words: sequential next is pc+1, not pc+4.
- Reset (reset_n=0, asynchronous, immediate, also mid-operation):
  - pc=RESET_PC.
  - instr_d=0, pc_plus1_d=0, valid_d=0.
  - fetch_count=0, stall_count=0.
  - imem_addr=RESET_PC while in reset.
- Defined: pc_plus1 = (pc+1) & (IMEM_DEPTH-1). Wrap: pc=IMEM_DEPTH-1 gives pc_plus1=0.
- Next-PC priority, evaluated each rising edge:
  1. jump_d=1: pc <= {pc_plus1_d[31:26], jump_target_d} & (IMEM_DEPTH-1).
  2. else pc_src_d=1: pc <= pc_branch_d & (IMEM_DEPTH-1).
  3. else stall_f=1: pc holds.
  4. else pc <= pc_plus1.
- A redirect overrides stall_f. jump_d has priority over pc_src_d when both are high.
- A redirect (jump_d|pc_src_d) is an internal flush of IF/ID; it is ORed with flush_d.
- IF/ID update priority:
  1. Flush (flush_d or redirect): instr_d<=0 (nop), pc_plus1_d<=0, valid_d<=0. Flush beats stall_d.
  2. else stall_d=1: IF/ID holds all fields, including valid_d.
  3. else instr_d<=imem_data, pc_plus1_d<=pc_plus1, valid_d<=1.
- Latency: the instruction at word N appears on instr_d one clock after pc=N.
- Each instruction is presented once per non-stalled cycle; there are no duplicates after a stall release.
- fetch_count increments by 1 on each edge where IF/ID loads under rule 3. It wraps at 2^32 to 0 with no saturation.
- stall_count increments on each edge with stall_f=1 and no redirect. It wraps at 2^32.
- stall_f=1 with stall_d=0 is legal: IF/ID reloads the same pc's instruction and fetch_count still increments. The hazard unit always pairs the two stalls.
- imem_data is sampled only at the edge; X on imem_data while flushed is don't-care.
- No internal state other than pc, the IF/ID fields and the two counters.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release with no stalls, RESET_PC=0 -> imem_addr goes 0,1,2,3 on consecutive cycles; instr_d trails imem_addr data by one cycle; valid_d=1 from the first edge after release; fetch_count=3 after 3 edges.
- Stall: assert stall_f=stall_d=1 for 2 cycles at pc=5 -> imem_addr holds 5; instr_d holds instr@4; stall_count=2. On release -> pc=6 next and instr_d=instr@5 exactly once.
- Jump: jump_d=1, jump_target_d=7 while pc=3 -> pc=7 next edge; IF/ID gets a nop with valid_d=0; fetch_count unchanged that edge. The following edge -> instr_d=instr@7, pc_plus1_d=8.
- Branch vs jump and stall: pc_src_d=1, pc_branch_d=0x20 with stall_f=1 -> pc=0x20, stall_count unchanged. pc_src_d=1 and jump_d=1 together with jump_target_d=1 -> pc=1.
- Wrap: IMEM_DEPTH=256, run to pc=255 -> next pc=0, pc_plus1_d=0 captured with instr@255. pc_branch_d=0x1_0003 -> pc=3.
- Flush/reset: flush_d=1 with stall_d=1 -> instr_d=0, valid_d=0. Then drop reset_n asynchronously mid-cycle -> pc, IF/ID and counters clear immediately, without waiting for a clock edge.
